edge_point_scanner: RTL

Upstream feeder of the Hough voting datapath. It raster-scans the 1-bit Canny edge map and presents each edge pixel's (x, y) to the pre/memo/max stages. It holds each point until the sequencing controller pulses `inc_address`, which happens when the theta sweep for that point completes. When no edge pixels remain, it raises `end_point`, which moves the controller into queue/post-processing.

---
 rtl/edge_point_scanner.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/edge_point_scanner.sv
// edge_point_scanner: raster-scans a 1-bit edge map and presents each edge pixel's (x, y) until consumed.
//   clk          clock; all state changes on posedge
//   reset        asynchronous active-high reset, forces IDLE
//   reset_canny  synchronous clear with the same effect as reset
//   frame_ready  level, edge map complete and readable (sampled only in IDLE)
//   inc_address  pulse, the presented point has been consumed (sampled only in PRESENT)
//   mem_rd       edge-map read strobe
//   mem_addr     edge-map read address, raster order y*IMG_W+x
//   mem_data     edge bit, valid the cycle after mem_rd
//   point_valid  x_out/y_out hold an edge point
//   x_out/y_out  coordinates of the presented point
//   end_point    scan exhausted, sticky until reset or reset_canny
//   edge_count   points presented this frame, saturating
// Optional feature: define SCAN_ROI_EN to start the scan at row ROI_Y0 instead of row 0.
module edge_point_scanner #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int X_W    = 9,
    parameter int Y_W    = 8,
    parameter int ADDR_W = 17,
    parameter int ROI_Y0 = 120
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_canny,
    input  logic              frame_ready,
    input  logic              inc_address,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data,
    output logic              point_valid,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic              end_point,
    output logic [15:0]       edge_count
);
    localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, PRESENT = 2'd2, DONE = 2'd3;
`ifdef SCAN_ROI_EN
    localparam int Y0 = ROI_Y0;
`else
    localparam int Y0 = 0 * ROI_Y0;
`endif
    localparam logic [X_W-1:0]    XL = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]    YL = Y_W'(IMG_H - 1);
    localparam logic [Y_W-1:0]    YS = Y_W'(Y0);
    localparam logic [ADDR_W-1:0] AS = ADDR_W'(Y0 * IMG_W);

    logic [1:0]        state_q, state_d;
    logic [X_W-1:0]    ix_q, ix_d, tx_q, tx_d, x_q, x_d;
    logic [Y_W-1:0]    iy_q, iy_d, ty_q, ty_d, y_q, y_d;
    logic [ADDR_W-1:0] ia_q, ia_d;
    logic              tv_q, tv_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              hit, tag_last, pt_last, issue_last;

    assign hit        = tv_q && mem_data;
    assign tag_last   = tx_q == XL && ty_q == YL;
    assign pt_last    = x_q == XL && y_q == YL;
    assign issue_last = ix_q == XL && iy_q == YL;

    // The issue pointer runs one pixel ahead of the tag, so on a hit simply
    // holding it lands on tag+1 and the overshoot read is dropped. After the
    // last pixel the pointer holds, re-reading that pixel harmlessly.
    always_comb begin
        state_d = state_q;
        ix_d    = ix_q;
        iy_d    = iy_q;
        ia_d    = ia_q;
        tv_d    = 1'b0;
        tx_d    = ix_q;
        ty_d    = iy_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    state_d = frame_ready ? SCAN : IDLE;
            SCAN: begin
                if (hit) begin
                    state_d = PRESENT;
                    x_d     = tx_q;
                    y_d     = ty_q;
                    cnt_d   = cnt_q + 16'(cnt_q != 16'hFFFF);
                end else if (tv_q && tag_last) begin
                    state_d = DONE;
                end else begin
                    tv_d = 1'b1;
                    if (!issue_last) begin
                        ix_d = ix_q == XL ? '0 : ix_q + 1'b1;
                        iy_d = iy_q + Y_W'(ix_q == XL);
                        ia_d = ia_q + 1'b1;
                    end
                end
            end
            PRESENT: state_d = inc_address ? (pt_last ? DONE : SCAN) : PRESENT;
            default: ;
        endcase
        if (reset_canny) begin
            state_d = IDLE;
            ix_d    = '0;
            iy_d    = YS;
            ia_d    = AS;
            tv_d    = 1'b0;
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ix_q    <= '0;
            iy_q    <= YS;
            ia_q    <= AS;
            tv_q    <= 1'b0;
            tx_q    <= '0;
            ty_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ix_q    <= ix_d;
            iy_q    <= iy_d;
            ia_q    <= ia_d;
            tv_q    <= tv_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_rd      = state_q == SCAN;
    assign mem_addr    = mem_rd ? ia_q : '0;
    assign point_valid = state_q == PRESENT;
    assign end_point   = state_q == DONE;
    assign x_out       = x_q;
    assign y_out       = y_q;
    assign edge_count  = cnt_q;
endmodule
